// File: rtl/dmem_bus_responder.sv
// -----------------------------------------------------------------------------
// dmem_bus_responder
//
// Data-memory-side responder for the MIPS core's load/store port. It takes one
// word request at a time, inserts WAIT_CYCLES wait states and then pulses
// `ready` for one cycle. Loads return registered data on rd_dm. Stores commit
// on the same edge that enters the response state.
//
// Address map (byte addresses, word aligned):
//   0 .. DEPTH*4-1   RAM, one 32-bit word per address
//   MMIO_BASE + 0    LED register (read/write, low 8 bits)
//   MMIO_BASE + 4    transaction counter (read-only)
//   MMIO_BASE + 8    free-running cycle counter (read-only). It exists only
//                    when DMEM_CYCLE_COUNTER_EN is defined; otherwise this
//                    address is out of range.
//   Any other address, or a misaligned one, faults: err = 1, rd_dm = 0 and
//   any store is dropped.
//
// Optional feature macro: DMEM_CYCLE_COUNTER_EN
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous active-high reset
//   req_valid  in   1   request strobe, held high until ready
//   we         in   1   1 = store, 0 = load
//   addr       in  32   byte address
//   wd_dm      in  32   store data
//   rd_dm      out 32   registered load data (0 after a store or a fault)
//   ready      out  1   one-cycle completion pulse
//   err        out  1   fault flag, only meaningful while ready = 1
//   led        out  8   LED register
// -----------------------------------------------------------------------------
module dmem_bus_responder #(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd_dm,
    output logic [31:0] rd_dm,
    output logic        ready,
    output logic        err,
    output logic [7:0]  led
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          WCW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WCW-1:0] WLOAD  = (WAIT_CYCLES > 0) ? WCW'(WAIT_CYCLES - 1) : '0;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
    localparam logic [31:0] LED_ADDR  = MMIO_BASE;
    localparam logic [31:0] TXN_ADDR  = MMIO_BASE + 32'd4;
`ifdef DMEM_CYCLE_COUNTER_EN
    localparam logic [31:0] CYC_ADDR  = MMIO_BASE + 32'd8;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [31:0]      wd_q, wd_d;
    logic [31:0]      rd_q;
    logic             err_q;
    logic [7:0]       led_q;
    logic [31:0]      txn_q;
    logic             enter_resp;

    logic [31:0]      mem [DEPTH];

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0]      cyc_q;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic. addr_d/we_d/wd_d are the request fields in effect on
    // this edge: the live inputs when accepting from IDLE, otherwise the
    // latched copies. With WAIT_CYCLES = 0 the accept edge is also the
    // response-entry edge, so decode must look at the live inputs.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wd_d       = wd_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = addr;
                    we_d   = we;
                    wd_d   = wd_dm;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        wcnt_d  = WLOAD;
                    end
                end
            end
            WAIT: begin
                if (wcnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Address decode on the effective request fields.
    // -------------------------------------------------------------------------
    logic          misaligned;
    logic          hit_ram;
    logic [AW-1:0] ram_idx;
    logic          dec_err;
    logic [31:0]   dec_rdata;
    logic          ram_wr;
    logic          led_wr;

    assign misaligned = (addr_d[1:0] != 2'b00);
    assign hit_ram    = !misaligned && (addr_d < RAM_BYTES);
    assign ram_idx    = addr_d[AW+1:2];

    always_comb begin
        dec_err   = 1'b0;
        dec_rdata = 32'd0;
        ram_wr    = 1'b0;
        led_wr    = 1'b0;
        if (hit_ram) begin
            if (we_d) ram_wr    = 1'b1;
            else      dec_rdata = mem[ram_idx];
        end else if (addr_d == LED_ADDR) begin
            if (we_d) led_wr    = 1'b1;
            else      dec_rdata = {24'd0, led_q};
        end else if (addr_d == TXN_ADDR) begin
            if (we_d) dec_err   = 1'b1;
            else      dec_rdata = txn_q;
`ifdef DMEM_CYCLE_COUNTER_EN
        end else if (addr_d == CYC_ADDR) begin
            if (we_d) dec_err   = 1'b1;
            else      dec_rdata = cyc_q;
`endif
        end else begin
            dec_err = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Control and response registers. The store commit, read data capture and
    // transaction count all happen on the response-entry edge. Because reset
    // has priority, a reset on that edge aborts the transaction.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            rd_q    <= 32'd0;
            err_q   <= 1'b0;
            led_q   <= 8'd0;
            txn_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (enter_resp) begin
                rd_q  <= dec_rdata;
                err_q <= dec_err;
                txn_q <= txn_q + 32'd1;
                if (led_wr) led_q <= wd_d[7:0];
            end
        end
    end

    // Request latch: data-only, so it is not reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        we_q   <= we_d;
        wd_q   <= wd_d;
    end

    // RAM contents survive reset. A reset on the commit edge blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && ram_wr) mem[ram_idx] <= wd_d;
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    always_ff @(posedge clk) begin
        if (rst) cyc_q <= 32'd0;
        else     cyc_q <= cyc_q + 32'd1;
    end
`endif

    assign ready = (state_q == RESP);
    assign err   = ready & err_q;
    assign rd_dm = rd_q;
    assign led   = led_q;

endmodule

// File: tb/tb_dmem_bus_responder.sv
module tb_dmem_bus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wd_dm = 32'd0;
    logic [31:0] rd_dm;
    logic        ready;
    logic        err;
    logic [7:0]  led;

    int checks = 0;
    int errors = 0;
    int n_txn  = 0;

    dmem_bus_responder #(
        .DEPTH      (64),
        .WAIT_CYCLES(2),
        .MMIO_BASE  (32'h0000_0800)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .we       (we),
        .addr     (addr),
        .wd_dm    (wd_dm),
        .rd_dm    (rd_dm),
        .ready    (ready),
        .err      (err),
        .led      (led)
    );

    always #5 clk = ~clk;

    // Issue one request and wait for ready. lat is the number of falling edges
    // from the request until ready is seen (3 for two wait states), or -1 on
    // timeout. spur is set if err was high while ready was low.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e, output int lat,
                          output logic spur);
        int i;
        logic found;
        @(negedge clk);
        req_valid = 1'b1;
        we        = w;
        addr      = a;
        wd_dm     = d;
        lat   = -1;
        rd    = 32'd0;
        e     = 1'b0;
        spur  = 1'b0;
        found = 1'b0;
        i     = 0;
        while (!found && i < 20) begin
            @(negedge clk);
            i++;
            if (ready) begin
                found = 1'b1;
                lat   = i;
                rd    = rd_dm;
                e     = err;
            end else if (err) begin
                spur = 1'b1;
            end
        end
        req_valid = 1'b0;
        we        = 1'b0;
        n_txn++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
        checks++; if (rd_dm !== 32'd0) begin errors++; $display("FAIL reset_rd got %h want 0", rd_dm); end
        checks++; if (led !== 8'd0) begin errors++; $display("FAIL reset_led got %h want 0", led); end
        rst = 1'b0;
        n_txn = 0;
    endtask

    task automatic test_ram;
        logic [31:0] rd; logic e; int lat; logic spur;
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, rd, e, lat, spur);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ram_store_latency got %0d want 3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL ram_store_err got %0b want 0", e); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL ram_store_rd got %h want 0", rd); end
        checks++; if (spur !== 1'b0) begin errors++; $display("FAIL ram_store_err_idle got %0b want 0", spur); end
        do_req(1'b0, 32'h10, 32'h0, rd, e, lat, spur);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ram_load_latency got %0d want 3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL ram_load_err got %0b want 0", e); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_load_rd got %h want deadbeef", rd); end
    endtask

    task automatic test_led;
        logic [31:0] rd; logic e; int lat; logic spur;
        do_req(1'b1, 32'h800, 32'h0000_01A5, rd, e, lat, spur);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL led_store_err got %0b want 0", e); end
        checks++; if (led !== 8'hA5) begin errors++; $display("FAIL led_value got %h want a5", led); end
        do_req(1'b0, 32'h800, 32'h0, rd, e, lat, spur);
        checks++; if (rd !== 32'h0000_00A5) begin errors++; $display("FAIL led_load_rd got %h want 000000a5", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL led_load_err got %0b want 0", e); end
    endtask

    task automatic test_faults;
        logic [31:0] rd; logic e; int lat; logic spur;
        do_req(1'b0, 32'h10, 32'h0, rd, e, lat, spur);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fault_pre_rd got %h want deadbeef", rd); end
        do_req(1'b0, 32'h13, 32'h0, rd, e, lat, spur);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL misaligned_err got %0b want 1", e); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL misaligned_rd got %h want 0", rd); end
        do_req(1'b0, 32'h400, 32'h0, rd, e, lat, spur);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL range_err got %0b want 1", e); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL range_rd got %h want 0", rd); end
        do_req(1'b1, 32'h804, 32'h5555_5555, rd, e, lat, spur);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL txn_store_err got %0b want 1", e); end
        do_req(1'b1, 32'h12, 32'h5555_5555, rd, e, lat, spur);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL misaligned_store_err got %0b want 1", e); end
        do_req(1'b0, 32'h10, 32'h0, rd, e, lat, spur);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fault_post_rd got %h want deadbeef", rd); end
    endtask

    task automatic test_back_to_back;
        int pulse_at[3];
        int npulse;
        int i;
        logic [31:0] rd; logic e; int lat; logic spur;
        int extra;
        @(negedge clk);
        req_valid = 1'b1;
        we        = 1'b0;
        addr      = 32'h10;
        npulse = 0;
        i = 0;
        while (npulse < 3 && i < 30) begin
            @(negedge clk);
            i++;
            if (ready) begin
                pulse_at[npulse] = i;
                npulse++;
            end
        end
        req_valid = 1'b0;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready) extra++;
        end
        n_txn += npulse;
        checks++; if (npulse + extra !== 3) begin errors++; $display("FAIL b2b_pulses got %0d want 3", npulse + extra); end
        if (npulse == 3) begin
            checks++; if (pulse_at[1] - pulse_at[0] !== 4) begin errors++; $display("FAIL b2b_spacing1 got %0d want 4", pulse_at[1] - pulse_at[0]); end
            checks++; if (pulse_at[2] - pulse_at[1] !== 4) begin errors++; $display("FAIL b2b_spacing2 got %0d want 4", pulse_at[2] - pulse_at[1]); end
        end
        begin
            int expect_cnt;
            expect_cnt = n_txn;
            do_req(1'b0, 32'h804, 32'h0, rd, e, lat, spur);
            checks++; if (rd !== 32'(expect_cnt)) begin errors++; $display("FAIL txn_count got %0d want %0d", rd, expect_cnt); end
            checks++; if (e !== 1'b0) begin errors++; $display("FAIL txn_load_err got %0b want 0", e); end
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd; logic e; int lat; logic spur;
        int pulses;
        do_req(1'b1, 32'h20, 32'hCAFE_F00D, rd, e, lat, spur);
        @(negedge clk);
        req_valid = 1'b1;
        we        = 1'b1;
        addr      = 32'h20;
        wd_dm     = 32'h1234_5678;
        @(negedge clk);            // accepted, now waiting
        req_valid = 1'b0;
        we        = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_ready got %0d pulses want 0", pulses); end
        checks++; if (led !== 8'd0) begin errors++; $display("FAIL abort_led got %h want 0", led); end
        n_txn = 0;
        do_req(1'b0, 32'h804, 32'h0, rd, e, lat, spur);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL abort_txn got %0d want 0", rd); end
        do_req(1'b0, 32'h20, 32'h0, rd, e, lat, spur);
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL abort_ram got %h want cafef00d", rd); end
    endtask

    task automatic test_cycle_counter;
`ifdef DMEM_CYCLE_COUNTER_EN
        logic [31:0] v[2];
        logic        ev[2];
        int          np;
        int          i;
        @(negedge clk);
        req_valid = 1'b1;
        we        = 1'b0;
        addr      = 32'h808;
        np = 0;
        i  = 0;
        while (np < 2 && i < 20) begin
            @(negedge clk);
            i++;
            if (ready) begin
                v[np]  = rd_dm;
                ev[np] = err;
                np++;
            end
        end
        req_valid = 1'b0;
        checks++; if (np !== 2) begin errors++; $display("FAIL cyc_pulses got %0d want 2", np); end
        if (np == 2) begin
            checks++; if (v[1] - v[0] !== 32'd4) begin errors++; $display("FAIL cyc_delta got %0d want 4", v[1] - v[0]); end
            checks++; if (ev[0] !== 1'b0 || ev[1] !== 1'b0) begin errors++; $display("FAIL cyc_err got %0b%0b want 00", ev[0], ev[1]); end
        end
`else
        logic [31:0] rd; logic e; int lat; logic spur;
        do_req(1'b0, 32'h808, 32'h0, rd, e, lat, spur);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL cyc_absent_err got %0b want 1", e); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL cyc_absent_rd got %h want 0", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_ram();
        test_led();
        test_faults();
        test_back_to_back();
        test_reset_abort();
        test_cycle_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
